// File: rtl/memory_bus_ctrl_pkg.sv
// memory_bus_ctrl_pkg
//   Shared project definitions for the processor/memory bus controller:
//   address/data index limits, FSM state encoding and the latched request
//   record. Imported by memory_bus_ctrl; nothing here is redefined locally.
package memory_bus_ctrl_pkg;

  localparam int ADDRESS_INDEX_LIMIT = 25;
  localparam int DATA_INDEX_LIMIT    = 31;

  typedef logic [ADDRESS_INDEX_LIMIT:0] addr_t;
  typedef logic [DATA_INDEX_LIMIT:0]    data_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } bus_state_e;

  // Request captured in IDLE and held for the whole access.
  typedef struct packed {
    logic  we;
    addr_t addr;
    data_t wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_timeout_cnt.sv
// bus_timeout_cnt
//   Counts ACCESS cycles spent waiting for the memory acknowledge.
//   Ports:
//     CLK     - clock, rising edge
//     RST     - synchronous active-high reset
//     clear   - force count to zero
//     enable  - advance count by one
//     expired - count has reached TIMEOUT-1 (last allowed wait cycle)
module bus_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // One spare bit so the counter cannot wrap before it reaches TIMEOUT-1.
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || clear) cnt <= '0;
    else if (enable)  cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/memory_bus_ctrl.sv
// memory_bus_ctrl
//   Bridges a level-held processor READ/WRITE request to a single-port memory
//   with a completion strobe. Four-phase handshake on the processor side:
//   READY stays high until both READ and WRITE drop. Accesses that see no
//   MEM_ACK within TIMEOUT cycles complete with BUS_ERR.
//   Ports:
//     CLK, RST             - clock, synchronous active-high reset
//     READ, WRITE          - processor request (READ&WRITE together is a fault)
//     ADDR, WDATA          - processor address / write data
//     RDATA, READY, BUS_ERR- processor response (all registered)
//     MEM_CS, MEM_WE       - memory strobes (registered)
//     MEM_ADDR, MEM_WDATA  - latched request to memory
//     MEM_RDATA, MEM_ACK   - memory response
module memory_bus_ctrl
  import memory_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         READ,
  input  logic                         WRITE,
  input  logic [ADDRESS_INDEX_LIMIT:0] ADDR,
  input  logic [DATA_INDEX_LIMIT:0]    WDATA,
  output logic [DATA_INDEX_LIMIT:0]    RDATA,
  output logic                         READY,
  output logic                         BUS_ERR,
  output logic                         MEM_CS,
  output logic                         MEM_WE,
  output logic [ADDRESS_INDEX_LIMIT:0] MEM_ADDR,
  output logic [DATA_INDEX_LIMIT:0]    MEM_WDATA,
  input  logic [DATA_INDEX_LIMIT:0]    MEM_RDATA,
  input  logic                         MEM_ACK
);

  bus_state_e state_q, state_d;
  bus_req_t   req_q, req_d;
  data_t      rdata_q, rdata_d;
  logic       ready_q, ready_d;
  logic       err_q, err_d;
  logic       cs_q, cs_d;
  logic       we_q, we_d;
  logic       cnt_clr, cnt_en, cnt_expired;

  bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (cnt_clr),
    .enable  (cnt_en),
    .expired (cnt_expired)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
    end
  end

  // Outputs are computed for the state being entered, so every output is a
  // flop and MEM_CS rises in the first ACCESS cycle.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    ready_d = ready_q;
    err_d   = err_q;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        ready_d = 1'b0;
        err_d   = 1'b0;
        if (READ && WRITE) begin
          // Ambiguous request: fault without touching memory.
          state_d = ST_DONE;
          ready_d = 1'b1;
          err_d   = 1'b1;
        end else if (READ || WRITE) begin
          state_d     = ST_ACCESS;
          req_d.we    = WRITE;
          req_d.addr  = ADDR;
          req_d.wdata = WDATA;
          cs_d        = 1'b1;
          we_d        = WRITE;
        end
      end

      ST_ACCESS: begin
        // ACK is checked before expiry so a last-cycle ACK still succeeds.
        if (MEM_ACK) begin
          state_d = ST_DONE;
          ready_d = 1'b1;
          err_d   = 1'b0;
          if (!req_q.we) rdata_d = MEM_RDATA;
        end else if (cnt_expired) begin
          state_d = ST_DONE;
          ready_d = 1'b1;
          err_d   = 1'b1;
          if (!req_q.we) rdata_d = '0;
        end else begin
          cs_d   = 1'b1;
          we_d   = req_q.we;
          cnt_en = 1'b1;
        end
      end

      ST_DONE: begin
        if (!READ && !WRITE) begin
          state_d = ST_IDLE;
          ready_d = 1'b0;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  assign RDATA     = rdata_q;
  assign READY     = ready_q;
  assign BUS_ERR   = err_q;
  assign MEM_CS    = cs_q;
  assign MEM_WE    = we_q;
  assign MEM_ADDR  = req_q.addr;
  assign MEM_WDATA = req_q.wdata;

endmodule
